uart_receiver: RTL and testbench

- Serial-to-parallel UART receive stage; the downstream consumer of the transmitter's tx line.
- Oversamples the incoming line using the shared baud-rate s_tick, which runs at 16 ticks per bit.
- Validates the start bit, shifts in D_BIT data bits LSB-first and checks the stop bit.
- Presents each byte with a one-clock rx_done_tick strobe, suitable as write_en for a receive FIFO (e.g. FIFO bits=8, depth=8).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_receiver.sv | 185 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame constants.
package uart_pkg;

  localparam int UART_OVS      = 16;
  localparam int UART_DBIT_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; both stages reset to 1 (line idle).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start/data/stop framing with registered strobes.
// Optional parity check and parity_err port enabled by defining UART_RX_PARITY_EN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int D_BIT   = UART_DBIT_DEF,
  parameter int SB_TICK = 16,
  parameter int OVS     = UART_OVS
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             s_tick,
  output logic [D_BIT-1:0] rx_dout,
  output logic             rx_done_tick,
  output logic             frame_err,
`ifdef UART_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int TICK_MAX = (SB_TICK > OVS) ? SB_TICK : OVS;
  localparam int TW       = $clog2(TICK_MAX);
  localparam int NW       = (D_BIT > 1) ? $clog2(D_BIT) : 1;

  localparam logic [TW-1:0] T_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(OVS - 1);
  localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(D_BIT - 1);

  logic             rx_s;
  rx_state_t        state, state_n;
  logic [TW-1:0]    tick, tick_n;
  logic [NW-1:0]    nbit, nbit_n;
  logic [D_BIT-1:0] sh, sh_n;
  logic [D_BIT-1:0] dout_n;
  logic             done_n, ferr_n;
  logic             armed, armed_n;
`ifdef UART_RX_PARITY_EN
  logic             pbit, pbit_n;
  logic             perr_n;
  logic             par_bad;

  assign par_bad = (^{sh, pbit}) != PARITY_ODD;
`endif

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      tick         <= '0;
      nbit         <= '0;
      sh           <= '0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      armed        <= 1'b1;
`ifdef UART_RX_PARITY_EN
      pbit         <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      tick         <= tick_n;
      nbit         <= nbit_n;
      sh           <= sh_n;
      rx_dout      <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
      armed        <= armed_n;
`ifdef UART_RX_PARITY_EN
      pbit         <= pbit_n;
      parity_err   <= perr_n;
`endif
    end
  end

  // armed drops after a low stop bit, so a held-low (break) line must go high
  // before another start edge is accepted.
  always_comb begin
    state_n = state;
    tick_n  = tick;
    nbit_n  = nbit;
    sh_n    = sh;
    dout_n  = rx_dout;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    armed_n = armed | rx_s;
`ifdef UART_RX_PARITY_EN
    pbit_n  = pbit;
    perr_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s && armed) begin
          state_n = START;
          tick_n  = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick == T_MID) begin
            if (!rx_s) begin
              state_n = DATA;
              tick_n  = '0;
              nbit_n  = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick == T_BIT) begin
            tick_n = '0;
            sh_n   = {rx_s, sh[D_BIT-1:1]};
            if (nbit == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              nbit_n = nbit + NW'(1);
            end
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (tick == T_BIT) begin
            tick_n  = '0;
            pbit_n  = rx_s;
            state_n = STOP;
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (tick == T_STOP) begin
            state_n = IDLE;
            tick_n  = '0;
            if (!rx_s) begin
              ferr_n  = 1'b1;
              armed_n = 1'b0;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              perr_n = 1'b1;
`endif
            end else begin
              done_n = 1'b1;
              dout_n = sh;
            end
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level scoreboard plus directed vectors.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int DB  = 8;
  localparam int OVS = 16;
  localparam int SB  = 16;
  localparam int CPT = 4;          // clk per s_tick
  localparam int CPB = OVS * CPT;  // clk per bit

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx = 1'b1;
  logic          s_tick = 1'b0;
  logic [DB-1:0] rx_dout;
  logic          rx_done_tick;
  logic          frame_err;
  logic          busy;
  logic          parity_err;

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  uart_receiver #(.D_BIT(DB), .SB_TICK(SB), .OVS(OVS)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;  // 0 byte received, 1 frame error, 2 parity error
    logic [7:0] data;
    int         due;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         busy_cyc = 0;
  logic [7:0] last_good = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Strobe is expected when the mid-point of the stop bit is reached:
  // half a start bit, all data (and parity) bits, then the stop bit.
  task automatic push_exp(input int kind, input logic [7:0] d, input bit has_par);
    ev_t e;
    e.kind = kind;
    e.data = d;
    e.due  = cyc + CPT * (OVS / 2 + OVS * DB + SB + (has_par ? OVS : 0));
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit has_par,
                            input logic par_v, input int kind);
    if (kind >= 0) push_exp(kind, d, has_par);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (has_par) drive_bit(par_v);
    drive_bit(stop_v);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int n = 0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (n == CPT - 1);
      n = (n + 1) % CPT;
    end
  end

  // Compare process: every strobe must match the next expected event in kind
  // and timing; rx_dout must always equal the last correctly received byte.
  initial begin
    ev_t  e;
    int   kind_now;
    logic prev_pulse = 1'b0;
    logic pulse;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_good = '0;
        check("reset_outputs", {rx_dout, rx_done_tick, frame_err, parity_err, busy}, '0);
        prev_pulse = 1'b0;
      end else begin
        pulse = rx_done_tick | frame_err | parity_err;
        if (busy) busy_cyc++;
        if (rx_done_tick) done_cnt++;
        if (frame_err) ferr_cnt++;
        if (parity_err) perr_cnt++;
        if (pulse) begin
          check("strobe_exclusive", int'(rx_done_tick) + int'(frame_err) + int'(parity_err), 1);
          check("strobe_single_clk", prev_pulse, 0);
          kind_now = rx_done_tick ? 0 : (frame_err ? 1 : 2);
          if (exp_q.size() == 0) begin
            check("unexpected_event", {rx_done_tick, frame_err, parity_err}, 0);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", kind_now, e.kind);
            check_range("event_time", cyc, e.due - 4, e.due + 8);
            if (e.kind == 0) last_good = e.data;
          end
        end
        check("rx_dout", rx_dout, last_good);
        prev_pulse = pulse;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_bits(3);
    check("idle_busy", busy, 0);

    // Single 8N1 frame
    b0 = busy_cyc;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
    idle_bits(2);
    drain("drain_a5");
    check("a5_dout", rx_dout, 8'hA5);
    check("a5_done_cnt", done_cnt, 1);
    check_range("a5_busy_span", busy_cyc - b0, 600, 615);

    // Short low glitch on an idle line
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_busy", busy, 1);
    idle_bits(2);
    check("glitch_idle", busy, 0);
    check("glitch_counts", {done_cnt[7:0], ferr_cnt[7:0]}, {8'd1, 8'd0});

    // Stop bit forced low
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1);
    idle_bits(2);
    drain("drain_3c");
    check("ferr_dout_kept", rx_dout, 8'hA5);
    check("ferr_cnt", ferr_cnt, 1);

    // Break: line held low for many bit times gives exactly one frame error
    push_exp(1, 8'h00, 1'b0);
    rx = 1'b0;
    repeat (20 * CPB) @(posedge clk);
    #1;
    idle_bits(2);
    drain("drain_break");
    check("break_ferr_cnt", ferr_cnt, 2);
    check("break_dout_kept", rx_dout, 8'hA5);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 0);
    idle_bits(2);
    drain("drain_b2b");
    check("b2b_dout", rx_dout, 8'h55);
    check("b2b_done_cnt", done_cnt, 4);

    // Reset in the middle of the data bits of 0x81
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_bits(3);
    check("post_reset_dout", rx_dout, 8'h00);
    check("post_reset_busy", busy, 0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 0);
    idle_bits(2);
    drain("drain_7e");
    check("7e_dout", rx_dout, 8'h7E);
    check("7e_done_cnt", done_cnt, 5);
    check("ferr_total", ferr_cnt, 2);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 0);
    idle_bits(2);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 2);
    idle_bits(2);
    drain("drain_parity");
    check("par_dout", rx_dout, 8'h07);
    check("par_done_cnt", done_cnt, 6);
    check("par_perr_cnt", perr_cnt, 1);
`else
    check("perr_cnt_none", perr_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
